// File: rtl/riscv_pkg.sv
// Shared RV32M definitions for the execute-stage multiply/divide unit:
// funct3 encodings, FSM state type and the special-case result constants.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  // Signed divide/remainder ops are the only ones that can overflow.
  function automatic logic isSignedDiv(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling for ex_muldiv: converts incoming operands to
// magnitudes according to the op's signedness, and applies the final negate
// plus high/low (or quotient/remainder) selection on the raw iterative result.
module muldiv_signfix
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_opA,
  input  logic [XLEN-1:0] i_opB,
  output logic [XLEN-1:0] o_magA,
  output logic [XLEN-1:0] o_magB,
  output logic            o_negMain,
  output logic            o_negRem,
  input  logic [2:0]      i_resFunct3,
  input  logic            i_resNegMain,
  input  logic            i_resNegRem,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  output logic [XLEN-1:0] o_result
);

  logic              w_signA;
  logic              w_signB;
  logic              w_negA;
  logic              w_negB;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  // Which operands are treated as two's-complement for the incoming op.
  always_comb begin
    w_signA = 1'b0;
    w_signB = 1'b0;
    case (i_funct3)
      F3_MULH:        begin w_signA = 1'b1; w_signB = 1'b1; end
      F3_MULHSU:      begin w_signA = 1'b1; end
      F3_DIV, F3_REM: begin w_signA = 1'b1; w_signB = 1'b1; end
      default:        ;
    endcase
  end

  assign w_negA    = w_signA & i_opA[XLEN-1];
  assign w_negB    = w_signB & i_opB[XLEN-1];
  assign o_magA    = w_negA ? -i_opA : i_opA;
  assign o_magB    = w_negB ? -i_opB : i_opB;
  assign o_negMain = w_negA ^ w_negB;
  assign o_negRem  = w_negA;

  // For multiplies hi/lo form the 64-bit product; for divides hi is the
  // remainder and lo the quotient.
  assign w_prod    = {i_hi, i_lo};
  assign w_prodFix = i_resNegMain ? -w_prod : w_prod;
  assign w_quot    = i_resNegMain ? -i_lo : i_lo;
  assign w_rem     = i_resNegRem ? -i_hi : i_hi;

  // Pick the architectural result half/part for the latched op.
  always_comb begin
    o_result = w_rem;
    case (i_resFunct3)
      F3_MUL:                       o_result = w_prodFix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_prodFix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              o_result = w_quot;
      F3_REM, F3_REMU:              o_result = w_rem;
      default:                      o_result = w_rem;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage. Stalls the
// pipeline while computing and pulses done for one cycle with the result.
// Optional macro MULDIV_FASTMUL_EN: multiplies use a registered 33x33 signed
// array product (done at T+2); divides stay iterative.
module ex_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rdIn,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  mdState_t        r_state;
  mdState_t        w_nextState;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opB;
  logic [2:0]      r_funct3;
  logic            r_negMain;
  logic            r_negRem;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rdOut;

  logic [XLEN-1:0] w_magA;
  logic [XLEN-1:0] w_magB;
  logic            w_negMain;
  logic            w_negRem;
  logic [XLEN-1:0] w_fixResult;
  logic            w_divZero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_specialResult;
  logic            w_isMul;
  logic [XLEN:0]   w_mulSum;
  logic [XLEN:0]   w_divShift;
  logic            w_qBit;
  logic [XLEN-1:0] w_nextHi;
  logic [XLEN-1:0] w_nextLo;
  logic            w_busyExit;
  logic [XLEN-1:0] w_busyResult;

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .i_funct3     (funct3),
    .i_opA        (opA),
    .i_opB        (opB),
    .o_magA       (w_magA),
    .o_magB       (w_magB),
    .o_negMain    (w_negMain),
    .o_negRem     (w_negRem),
    .i_resFunct3  (r_funct3),
    .i_resNegMain (r_negMain),
    .i_resNegRem  (r_negRem),
    .i_hi         (w_nextHi),
    .i_lo         (w_nextLo),
    .o_result     (w_fixResult)
  );

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign w_divZero = funct3[2] & (opB == '0);
  assign w_ovf     = isSignedDiv(funct3) & (opA == INT_MIN) & (opB == '1);
  assign w_special = w_divZero | w_ovf;
  assign w_specialResult = funct3[1] ? (w_divZero ? opA : '0)
                                     : (w_divZero ? DIV0_QUOT : INT_MIN);

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  assign w_isMul    = ~r_funct3[2];
  assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : '0);
  assign w_divShift = {r_hi, r_lo[XLEN-1]};
  assign w_qBit     = (w_divShift >= {1'b0, r_opB});
  assign w_nextHi   = w_isMul ? w_mulSum[XLEN:1]
                              : (w_qBit ? (w_divShift[XLEN-1:0] - r_opB) : w_divShift[XLEN-1:0]);
  assign w_nextLo   = w_isMul ? {w_mulSum[0], r_lo[XLEN-1:1]}
                              : {r_lo[XLEN-2:0], w_qBit};

`ifdef MULDIV_FASTMUL_EN
  logic signed [XLEN:0]     r_fastA;
  logic signed [XLEN:0]     r_fastB;
  logic signed [2*XLEN+1:0] w_fastProd;
  logic [XLEN-1:0]          w_fastResult;
  logic                     w_fastSignA;
  logic                     w_fastSignB;

  assign w_fastSignA  = (funct3 == F3_MULH) | (funct3 == F3_MULHSU);
  assign w_fastSignB  = (funct3 == F3_MULH);
  assign w_fastProd   = r_fastA * r_fastB;
  assign w_fastResult = (r_funct3 == F3_MUL) ? w_fastProd[XLEN-1:0]
                                             : w_fastProd[2*XLEN-1:XLEN];
  assign w_busyExit   = w_isMul | (r_count == LAST);
  assign w_busyResult = w_isMul ? w_fastResult : w_fixResult;

  // Sign-extended operand capture feeding the single-cycle array multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fastA <= '0;
      r_fastB <= '0;
    end else if ((r_state == IDLE) && start && !flush) begin
      r_fastA <= {w_fastSignA & opA[XLEN-1], opA};
      r_fastB <= {w_fastSignB & opB[XLEN-1], opB};
    end
  end
`else
  assign w_busyExit   = (r_count == LAST);
  assign w_busyResult = w_fixResult;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; flush always wins over start and over completion.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start && !flush) w_nextState = w_special ? DONE : BUSY;
      BUSY: begin
        if (flush)           w_nextState = IDLE;
        else if (w_busyExit) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Pipeline-facing status outputs decoded from the state.
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      IDLE:    stall = start & ~flush;
      BUSY:    begin stall = 1'b1; busy = 1'b1; end
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Operand load, per-cycle iteration and result capture on the exit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opB     <= '0;
      r_funct3  <= '0;
      r_negMain <= 1'b0;
      r_negRem  <= 1'b0;
      r_result  <= '0;
      r_rdOut   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_funct3  <= funct3;
            r_rdOut   <= rdIn;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= w_magA;
            r_opB     <= w_magB;
            r_negMain <= w_negMain;
            r_negRem  <= w_negRem;
            if (w_special) r_result <= w_specialResult;
          end
        end
        BUSY: begin
          if (!flush) begin
            r_count <= r_count + 1'b1;
            r_hi    <= w_nextHi;
            r_lo    <= w_nextLo;
            if (w_busyExit) r_result <= w_busyResult;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign rdOut  = r_rdOut;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected results with their
// due cycle, an independent monitor pops and compares on every done pulse.
module tb_ex_muldiv;

`ifdef MULDIV_FASTMUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT  = 33;
  localparam int FAST_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [4:0]  rdIn = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rdOut;

  ex_muldiv #(.XLEN(32), .ITER(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .rdIn   (rdIn),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rdOut  (rdOut)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt++;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic [4:0]  rd;
    int          doneCycle;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t expQ[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   doneCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Issue one instruction for a single cycle, queue its expectation and
  // verify how long the pipeline was frozen.
  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [31:0] expRes, input int lat);
    int t0;
    int stallCnt;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; opA = a; opB = b; rdIn = rd;
    t0 = cycleCnt;
    expQ.push_back('{name, expRes, rd, t0 + lat});
    stallCnt = 0;
    seen = 1'b0;
    @(negedge clk);
    if (stall) stallCnt++;
    if (done) seen = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (done) seen = 1'b1;
    end
    checkOutput({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    checkOutput({name, "_stall_cycles"}, stallCnt, lat);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && done) begin
        doneCount++;
        if (expQ.size() == 0) begin
          checkOutput("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, "_result"}, result, e.result);
          checkOutput({e.name, "_rdOut"}, {27'b0, rdOut}, {27'b0, e.rd});
          checkOutput({e.name, "_done_cycle"}, cycleCnt, e.doneCycle);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] lastExp;
    int t0;
    int doneBase;

    vecs.push_back('{"mul_7x6",      3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       MUL_LAT});
    vecs.push_back('{"mulh_min",     3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, MUL_LAT});
    vecs.push_back('{"mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, MUL_LAT});
    vecs.push_back('{"mulhsu_neg",   3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{"mulhsu_ubig",  3'b010, 32'd2,        32'hFFFFFFFF, 5'd9,  32'h00000001, MUL_LAT});
    vecs.push_back('{"mul_max_lo",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000001, MUL_LAT});
    vecs.push_back('{"mulh_m3x5",    3'b001, 32'hFFFFFFFD, 32'd5,        5'd11, 32'hFFFFFFFF, MUL_LAT});
    vecs.push_back('{"div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{"rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, DIV_LAT});
    vecs.push_back('{"div_20_m3",    3'b100, 32'd20,       32'hFFFFFFFD, 5'd14, 32'hFFFFFFFA, DIV_LAT});
    vecs.push_back('{"rem_20_m3",    3'b110, 32'd20,       32'hFFFFFFFD, 5'd15, 32'd2,        DIV_LAT});
    vecs.push_back('{"divu_100_7",   3'b101, 32'd100,      32'd7,        5'd16, 32'd14,       DIV_LAT});
    vecs.push_back('{"remu_100_7",   3'b111, 32'd100,      32'd7,        5'd17, 32'd2,        DIV_LAT});
    vecs.push_back('{"divu_by0",     3'b101, 32'd5,        32'd0,        5'd18, 32'hFFFFFFFF, FAST_LAT});
    vecs.push_back('{"div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, FAST_LAT});
    vecs.push_back('{"remu_by0",     3'b111, 32'd5,        32'd0,        5'd20, 32'd5,        FAST_LAT});
    vecs.push_back('{"rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'd0,        FAST_LAT});

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy",   {31'b0, busy},   32'd0);
    checkOutput("reset_done",   {31'b0, done},   32'd0);
    checkOutput("reset_stall",  {31'b0, stall},  32'd0);
    checkOutput("reset_result", result,          32'd0);
    checkOutput("reset_rdOut",  {27'b0, rdOut},  32'd0);

    lastExp = '0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);
      lastExp = vecs[i].exp;
    end

    // Flush in the middle of a divide: no done, old result kept.
    doneBase = doneCount;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b101; opA = 32'd100; opB = 32'd7; rdIn = 5'd25;
    t0 = cycleCnt;
    @(posedge clk); #1;
    start = 1'b0;
    while (cycleCnt < t0 + 10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_t10_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_t11_busy",   {31'b0, busy},  32'd0);
    checkOutput("flush_t11_stall",  {31'b0, stall}, 32'd0);
    checkOutput("flush_t11_result", result,         lastExp);
    repeat (40) @(negedge clk);
    checkOutput("flush_no_done", doneCount - doneBase, 32'd0);

    // Asynchronous reset in the middle of a multiply.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; opA = 32'd7; opB = 32'd6; rdIn = 5'd26;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("midreset_busy",   {31'b0, busy},  32'd0);
    checkOutput("midreset_stall",  {31'b0, stall}, 32'd0);
    checkOutput("midreset_result", result,         32'd0);
    checkOutput("midreset_rdOut",  {27'b0, rdOut}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // Back-to-back multiplies with start held high through DONE.
    doneBase = doneCount;
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; opA = 32'd3; opB = 32'd5; rdIn = 5'd22;
    t0 = cycleCnt;
    expQ.push_back('{"b2b_first", 32'd15, 5'd22, t0 + MUL_LAT});
    expQ.push_back('{"b2b_second", 32'd81, 5'd23, t0 + MUL_LAT + 1 + MUL_LAT});
    repeat (MUL_LAT) @(posedge clk);
    #1;
    opA = 32'd9; opB = 32'd9; rdIn = 5'd23;
    @(negedge clk);
    checkOutput("b2b_done_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b_restart_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MUL_LAT + 10) @(negedge clk);
    checkOutput("b2b_done_pulses", doneCount - doneBase, 32'd2);

    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
